countdown_timer: RTL and testbench
==================================

# countdown_timer

Two-digit BCD countdown timer: the count-down counterpart of the up-counting stopwatch. It loads a preset from 00 to 99 and decrements once per `tick` strobe while running. On reaching 00 it raises an alarm for a programmable number of ticks, then re-arms to the preset. The parent feeds `BCD0`/`BCD1` into the existing `seven_segments` driver, exactly as the stopwatch does.

## Interface

**Parameters**
- `INIT_TENS`, default 4'd3: preset tens digit after reset.
- `INIT_ONES`, default 4'd0: preset ones digit after reset.
- `ALARM_TICKS`, default 4: number of ticks `alarm` stays high, legal range 1–15.

**Ports**
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `tick`, input, 1: one-cycle count strobe, generated by the parent's divider.
- `load`, input, 1: one-cycle pulse that latches `load_tens`/`load_ones` as the new preset.
- `load_tens`, input, 4: preset tens digit.
- `load_ones`, input, 4: preset ones digit.
- `start`, input, 1: one-cycle pulse that starts, resumes, or acknowledges the alarm.
- `pause`, input, 1: one-cycle pulse that pauses a running count.
- `BCD0`, output, 4: current ones digit.
- `BCD1`, output, 4: current tens digit.
- `running`, output, 1: high in RUN.
- `alarm`, output, 1: high in ALARM.
- `done`, output, 1: one-cycle pulse when the count reaches 00.

## Operation

**Reset values:** state IDLE; preset = {`INIT_TENS`, `INIT_ONES`}; `BCD1`/`BCD0` = preset; `running`, `alarm`, `done` = 0; alarm counter = 0.

**States**
- IDLE
  - `load` → preset and count both take the loaded digits.
  - `start` with count ≠ 00 → RUN. `start` with count = 00 → stay in IDLE.
- RUN, on `tick`:
  - Ones ≠ 0 → ones − 1.
  - Ones = 0 → ones = 9 and tens − 1 (borrow).
  - Count = 01 at the tick → count becomes 00, `done` pulses, next state ALARM.
  - `pause` → PAUSE.
- PAUSE
  - Count holds and ticks are ignored.
  - `start` → RUN; `start` at count 00 → stay in PAUSE.
  - `load` → preset and count both take the loaded digits.
- ALARM
  - `alarm` = 1 and the count shows 00.
  - Each tick increments the alarm counter.
  - When the counter reaches `ALARM_TICKS` → IDLE. Count reloads from the preset, counter clears.
  - `start` → IDLE immediately, with the same reload.

**Digit and event rules**
- Load digit > 9 → clamped to 9, so `load_ones` = 4'hC stores 9.
- `load` is ignored in RUN and ALARM.
- `tick` is ignored in IDLE and PAUSE.
- Simultaneous events:
  - `tick` + `pause` in RUN: the decrement is applied, then the state is PAUSE.
  - `start` + `pause` in RUN: `pause` wins. Elsewhere, `pause` is ignored.
  - `load` + `start` in IDLE/PAUSE: `load` wins and `start` is dropped.
  - `tick` + `start` in ALARM: `start` wins (immediate IDLE). The tick is not counted.
- `reset` at any cycle, mid-count or mid-alarm, restores all reset values on the next edge and discards any user load.
- `BCD1`/`BCD0` never hold a value > 9. The tens digit never underflows, because 00 is only reachable through the ALARM transition.

## Timing

- All outputs are registered. An event sampled at edge n is visible after edge n.
- `tick` at edge n in RUN updates `BCD0`/`BCD1` at n. From count 01, `done` = 1 for exactly the cycle following edge n, and `alarm` and state ALARM start at that same edge.
- `running` rises at the edge that samples `start` and falls at the edge that samples `pause`, or at the final tick.
- Alarm length is exactly `ALARM_TICKS` ticks: `alarm` falls at the edge sampling the `ALARM_TICKS`-th tick after entry, and the reloaded count appears at that same edge.
- No combinational path from inputs to outputs.

## Structure

**Shared package (`timer_pkg`)**
- State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3.
- BCD digit width constant (4).
- Digit max constant (9).

**Sub-module `bcd_down_counter`**
- Two-digit decrement with borrow.
- Synchronous load with clamp.
- `is_one` and `is_zero` flags.
- No FSM inside.

**`countdown_timer` top**
- FSM.
- Preset register.
- Alarm tick counter.
- Output registers.
- The `seven_segments` instance stays in the parent.

## Test plan

1. Reset, then `start`, then 3 ticks → BCD 30 → 29 → 28 → 27; `running` = 1 throughout.
2. `load` 0/2, `start`, 2 ticks → 02, 01, 00. `done` is high for exactly one cycle; `alarm` is high; after 4 further ticks `alarm` = 0, state IDLE, BCD = 02.
3. `load` 1/0, `start`, 1 tick → BCD = 09 (borrow). `pause` + `tick` in the same cycle → 08 and `running` = 0. 3 more ticks → still 08. `start` → resumes.
4. `load` with tens = 4'hF, ones = 4'hA → preset 99. `load` during RUN → ignored, count unaffected. `load` + `start` together in IDLE → loaded and state stays IDLE.
5. `start` at count 00 (after loading 0/0) → stays IDLE with `running` = 0. In ALARM, `start` + `tick` in the same cycle → IDLE at once with the count reloaded.
6. `reset` asserted mid-RUN at count 17 → next cycle BCD = 30, all flags 0, state IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  // Saturate a raw nibble to a legal BCD digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with clamped synchronous load and registered
// one/zero flags.
module bcd_down_counter
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] INIT_TENS = 4'd3,
  parameter logic [DIGIT_W-1:0] INIT_ONES = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_tens,
  input  logic [DIGIT_W-1:0] load_ones,
  input  logic               dec,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               is_one,
  output logic               is_zero
);

  localparam logic [DIGIT_W-1:0] RST_TENS = clamp_digit(INIT_TENS);
  localparam logic [DIGIT_W-1:0] RST_ONES = clamp_digit(INIT_ONES);

  logic [DIGIT_W-1:0] tens_d;
  logic [DIGIT_W-1:0] ones_d;

  // Load has priority; decrement holds at 00 so the tens digit cannot wrap.
  always_comb begin
    tens_d = tens;
    ones_d = ones;
    if (load) begin
      tens_d = clamp_digit(load_tens);
      ones_d = clamp_digit(load_ones);
    end else if (dec && !is_zero) begin
      if (ones != '0) begin
        ones_d = ones - DIGIT_W'(1);
      end else begin
        ones_d = DIGIT_MAX;
        tens_d = tens - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens    <= RST_TENS;
      ones    <= RST_ONES;
      is_one  <= (RST_TENS == '0) && (RST_ONES == DIGIT_W'(1));
      is_zero <= (RST_TENS == '0) && (RST_ONES == '0);
    end else begin
      tens    <= tens_d;
      ones    <= ones_d;
      is_one  <= (tens_d == '0) && (ones_d == DIGIT_W'(1));
      is_zero <= (tens_d == '0) && (ones_d == '0);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer: preset load, run/pause control, and an
// alarm held for a fixed number of ticks before re-arming to the preset.
module countdown_timer
  import timer_pkg::*;
#(
  parameter logic [3:0]  INIT_TENS   = 4'd3,
  parameter logic [3:0]  INIT_ONES   = 4'd0,
  parameter int unsigned ALARM_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_tens,
  input  logic [DIGIT_W-1:0] load_ones,
  input  logic               start,
  input  logic               pause,
  output logic [DIGIT_W-1:0] BCD0,
  output logic [DIGIT_W-1:0] BCD1,
  output logic               running,
  output logic               alarm,
  output logic               done
);

  localparam int unsigned ACNT_W = 4;
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_TICKS - 1);

  state_t             state_q;
  state_t             next_state;
  logic [DIGIT_W-1:0] preset_tens_q;
  logic [DIGIT_W-1:0] preset_ones_q;
  logic               preset_we;
  logic [ACNT_W-1:0]  alarm_cnt_q;
  logic [ACNT_W-1:0]  alarm_cnt_d;
  logic               cnt_load;
  logic [DIGIT_W-1:0] cnt_load_tens;
  logic [DIGIT_W-1:0] cnt_load_ones;
  logic               cnt_dec;
  logic               cnt_is_one;
  logic               cnt_is_zero;
  logic               done_d;

  bcd_down_counter #(
    .INIT_TENS(INIT_TENS),
    .INIT_ONES(INIT_ONES)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_tens(cnt_load_tens),
    .load_ones(cnt_load_ones),
    .dec      (cnt_dec),
    .tens     (BCD1),
    .ones     (BCD0),
    .is_one   (cnt_is_one),
    .is_zero  (cnt_is_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      preset_tens_q <= clamp_digit(INIT_TENS);
      preset_ones_q <= clamp_digit(INIT_ONES);
      alarm_cnt_q   <= '0;
      running       <= 1'b0;
      alarm         <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q     <= next_state;
      alarm_cnt_q <= alarm_cnt_d;
      running     <= (next_state == RUN);
      alarm       <= (next_state == ALARM);
      done        <= done_d;
      if (preset_we) begin
        preset_tens_q <= clamp_digit(load_tens);
        preset_ones_q <= clamp_digit(load_ones);
      end
    end
  end

  // Next state and datapath controls; the counter reloads from the preset by default.
  always_comb begin
    next_state    = state_q;
    alarm_cnt_d   = alarm_cnt_q;
    preset_we     = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_tens = preset_tens_q;
    cnt_load_ones = preset_ones_q;
    cnt_dec       = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE, PAUSE: begin
        if (load) begin
          preset_we     = 1'b1;
          cnt_load      = 1'b1;
          cnt_load_tens = load_tens;
          cnt_load_ones = load_ones;
        end else if (start && !cnt_is_zero) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          cnt_dec = 1'b1;
        end
        // Reaching 00 takes precedence over a coincident pause.
        if (tick && cnt_is_one) begin
          done_d      = 1'b1;
          alarm_cnt_d = '0;
          next_state  = ALARM;
        end else if (pause) begin
          next_state = PAUSE;
        end
      end
      ALARM: begin
        if (start || (tick && (alarm_cnt_q == ALARM_LAST))) begin
          cnt_load    = 1'b1;
          alarm_cnt_d = '0;
          next_state  = IDLE;
        end else if (tick) begin
          alarm_cnt_d = alarm_cnt_q + ACNT_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (preset 30, 4-tick alarm).
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic [3:0] BCD0;
  logic [3:0] BCD1;
  logic       running;
  logic       alarm;
  logic       done;

  int pass_cnt;
  int total_cnt;
  logic [10:0] obs;
  logic [10:0] exp_v;

  countdown_timer #(
    .INIT_TENS  (4'd3),
    .INIT_ONES  (4'd0),
    .ALARM_TICKS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (load),
    .load_tens(load_tens),
    .load_ones(load_ones),
    .start    (start),
    .pause    (pause),
    .BCD0     (BCD0),
    .BCD1     (BCD1),
    .running  (running),
    .alarm    (alarm),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic t, input logic l, input logic s,
                       input logic p, input logic [3:0] lt, input logic [3:0] lo);
    @(negedge clk);
    reset = r; tick = t; load = l; start = s; pause = p;
    load_tens = lt; load_ones = lo;
    @(posedge clk);
    #1;
    reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    obs = {BCD1, BCD0, running, alarm, done};
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_state got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_countdown;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    exp_v = {4'd3, 4'd0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL cd_start got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd2, 4'd9, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL cd_tick29 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd2, 4'd8, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL cd_tick28 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd2, 4'd7, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL cd_tick27 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_alarm;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 1, 0, 0, 4'd0, 4'd2);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd2, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL al_start got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd1, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL al_01 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL al_done got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL al_done_1cyc got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
      exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
      total_cnt++;
      if (obs !== exp_v) $display("FAIL al_hold%0d got=%h want=%h", i, obs, exp_v);
      else pass_cnt++;
    end
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL al_rearm got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd2, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL al_restart got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_borrow_pause;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 1, 0, 0, 4'd1, 4'd0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd9, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bp_borrow got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 1, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd8, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bp_pause_tick got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
      exp_v = {4'd0, 4'd8, 1'b0, 1'b0, 1'b0};
      total_cnt++;
      if (obs !== exp_v) $display("FAIL bp_paused%0d got=%h want=%h", i, obs, exp_v);
      else pass_cnt++;
    end
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd8, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bp_resume got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd7, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bp_resume_tick got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_load_rules;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 1, 0, 0, 4'hF, 4'hA);
    exp_v = {4'd9, 4'd9, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL ld_clamp got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd9, 4'd8, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL ld_run_tick got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 0, 1, 0, 0, 4'd3, 4'd3);
    exp_v = {4'd9, 4'd8, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL ld_in_run got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 1, 1, 0, 4'd1, 4'd5);
    exp_v = {4'd1, 4'd5, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL ld_start_same got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    exp_v = {4'd1, 4'd5, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL ld_then_start got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_zero_and_ack;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 1, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL zr_start_at_00 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 0, 1, 0, 0, 4'd0, 4'd1);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL zr_alarm_entry got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 1, 0, 1, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL zr_ack_tick got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL zr_idle_tick got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 1, 0, 0, 4'd2, 4'd0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd1, 4'd7, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL rm_at17 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL rm_reset got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
    exp_v = {4'd2, 4'd9, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL rm_preset_restored got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_tens = 4'd0; load_ones = 4'd0;
    test_reset;
    test_countdown;
    test_alarm;
    test_borrow_pause;
    test_load_rules;
    test_zero_and_ack;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
